// File: rtl/count_sequencer.sv
// Arm/run/abort/complete controller for a prescaled WIDTH-bit up-counter.
// Define CNT_SEQ_AUTORELOAD_EN to enable auto-reload on terminal tick.
module count_sequencer #(
    parameter int WIDTH = 4,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PS_W-1:0]  prescale,
    input  logic             reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt, tc_reg, tc_nxt;
    logic [PS_W-1:0]  ps_cnt, ps_cnt_nxt, ps_reg, ps_nxt;
    logic             busy_nxt, done_nxt, tick, term;
    logic             rl_reg;

`ifdef CNT_SEQ_AUTORELOAD_EN
    logic rl_nxt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rl_reg <= 1'b0;
        else        rl_reg <= rl_nxt;
    end
`else
    logic unused_reload;
    assign unused_reload = reload;
    assign rl_reg        = 1'b0;
`endif

    assign tick = (ps_cnt == ps_reg);
    assign term = tick && ((q + WIDTH'(1)) == tc_reg);

    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        ps_cnt_nxt = ps_cnt;
        tc_nxt     = tc_reg;
        ps_nxt     = ps_reg;
        done_nxt   = 1'b0;
`ifdef CNT_SEQ_AUTORELOAD_EN
        rl_nxt     = rl_reg;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    tc_nxt     = load_val;
                    ps_nxt     = prescale;
`ifdef CNT_SEQ_AUTORELOAD_EN
                    rl_nxt     = reload;
`endif
                    q_nxt      = '0;
                    ps_cnt_nxt = '0;
                    state_nxt  = (load_val == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    ps_cnt_nxt = '0;
                    if (term) begin
                        done_nxt = 1'b1;
                        if (rl_reg) begin
                            q_nxt = '0;
                        end else begin
                            q_nxt     = tc_reg;
                            state_nxt = DONE;
                        end
                    end else begin
                        q_nxt = q + WIDTH'(1);
                    end
                end else begin
                    ps_cnt_nxt = ps_cnt + PS_W'(1);
                end
            end
            DONE: begin
                // A zero terminal count arrives here with done low; it spends one
                // extra cycle so the pulse lands one edge after the accepting edge.
                if (!done) done_nxt  = 1'b1;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            q      <= '0;
            ps_cnt <= '0;
            tc_reg <= '0;
            ps_reg <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            ps_cnt <= ps_cnt_nxt;
            tc_reg <= tc_nxt;
            ps_reg <= ps_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Controller that sequences a WIDTH-bit up-counter datapath: it latches a terminal count and prescale ratio on a start request, advances the counter on prescaled ticks, and reports completion with a one-cycle done pulse. It sits between a requesting host and a counter datapath, owning arm, run, abort and completion.

## Interface
- WIDTH, 4, counter and terminal-count width
- PS_W, 4, prescale field width; tick period = prescale+1 cycles
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- stop  in  1  abort; sampled in RUN and IDLE
- load_val  in  WIDTH  terminal count, latched on accepted start
- prescale  in  PS_W  tick divider, latched on accepted start
- reload  in  1  auto-reload request, latched on accepted start (used only with CNT_SEQ_AUTORELOAD_EN)
- q  out  WIDTH  counter value
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: start=1 and stop=0 -> latch tc_reg=load_val, ps_reg=prescale, rl_reg=reload; q<=0, ps_cnt<=0; next RUN. If load_val==0, next state is DONE directly (q stays 0).
- start and stop both high in IDLE: stop wins, remain IDLE, nothing latched.
- RUN, each cycle: if stop=1 -> IDLE, q holds its value, no done. Otherwise, if ps_cnt==ps_reg, this is a tick: ps_cnt<=0, q<=q+1; else ps_cnt<=ps_cnt+1.
- Terminal tick (tick with q+1==tc_reg): q<=tc_reg, next DONE.
- stop has priority over a coinciding terminal tick: abort, no done, q holds its pre-tick value.
- DONE: done=1 for exactly this cycle; next IDLE unconditionally; q holds tc_reg.
- start in RUN or DONE is ignored and not queued.
- Arithmetic: q and ps_cnt are unsigned, modulo 2^WIDTH / 2^PS_W. tc_reg=2^WIDTH-1 is legal; q never wraps in one-shot mode.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, q=0, busy=0, done=0, ps_cnt=0, tc_reg=0, ps_reg=0, rl_reg=0. Takes effect immediately, including mid-RUN. First start is accepted at the first rising edge after reset deasserts.
- Start accepted at edge k: busy=1 and q=0 from edge k.
- Edge k+n*(ps_reg+1) gives q=n.
- Terminal tick at edge k+tc*(ps_reg+1): q=tc, busy=0, done=1 from that edge.
- Edge k+tc*(ps_reg+1)+1: done=0, IDLE. A new start can be accepted at this edge.
- load_val=0: done=1 from edge k+1, busy never asserts.
- Abort: stop sampled at edge m gives busy=0 from edge m.

## Configuration
- CNT_SEQ_AUTORELOAD_EN defined: if rl_reg=1, a terminal tick does not enter DONE. Instead q<=0, ps_cnt<=0, done=1 for one cycle, and the block stays in RUN (busy stays 1). Period = tc_reg*(ps_reg+1) cycles. Only stop or reset leaves RUN. With load_val=0 and reload=1, one-shot behaviour applies.
- Not defined: the reload input and rl_reg are ignored (rl_reg is tied to 0); every run is one-shot.

## Test plan
- Reset mid-RUN (load_val=5, prescale=0, reset low at q=3) -> q=0, busy=0, done=0 immediately; a start after release works normally.
- One-shot: load_val=3, prescale=0 -> q=1,2,3 on edges k+1..k+3; done=1 for the single cycle after k+3; busy low at k+3.
- Prescale: load_val=2, prescale=3 -> q increments every 4 cycles; done at edge k+8; q=2 held in IDLE.
- Abort and priority: stop at q=2 (load_val=4) -> IDLE, q=2, no done. Stop coinciding with terminal tick -> no done, q=3. start+stop together in IDLE -> stays IDLE.
- Edge cases: load_val=0 -> done at k+1, busy never high. load_val=15 (WIDTH=4) -> q reaches 15 and does not wrap. start pulsed during RUN -> ignored.
- CNT_SEQ_AUTORELOAD_EN, reload=1, load_val=2, prescale=1 -> done pulses every 4 cycles, q sequence 0,1,0,1; busy stays 1 until stop.
